// File: rtl/seg_pkg.sv
// Segment patterns and BCD helpers shared by the display scanner.
// Patterns are active-low {a,b,c,d,e,f,g,dp}; dp bit is 1 (off) in every pattern.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [3:0] BCD_BLANK = 4'hA;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_bcd_scan_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one shift per clock.
// bcd/ovf are result registers: they only change on the cycle done is raised.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int DIGITS = 4
) (
  input  logic                  s_clk,
  input  logic                  s_rst_n,
  input  logic                  load,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf
);

  localparam int SR_W  = DIGITS*4 + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [SR_W-1:0]     sr_q, sr_d, adj_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d;

  // add-3 correction of every BCD nibble ahead of the shift
  always_comb begin
    adj_s = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[DATA_W+4*i +: 4] >= 4'd5) begin
        adj_s[DATA_W+4*i +: 4] = sr_q[DATA_W+4*i +: 4] + 4'd3;
      end else begin
        adj_s[DATA_W+4*i +: 4] = sr_q[DATA_W+4*i +: 4];
      end
    end
  end

  // a new load always restarts; finishing is judged on the old state so both can coincide
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    if (load) begin
      sr_d      = {{(DIGITS*4){1'b0}}, bin_in};
      cnt_d     = CNT_W'(DATA_W);
      busy_d    = 1'b1;
      ovf_acc_d = 1'b0;
    end else if (busy_q && (cnt_q != '0)) begin
      sr_d      = {adj_s[SR_W-2:0], 1'b0};
      cnt_d     = cnt_q - CNT_W'(1);
      ovf_acc_d = ovf_acc_q | adj_s[SR_W-1];
    end else begin
      busy_d    = 1'b0;
    end
    if (busy_q && (cnt_q == '0)) begin
      done_d = 1'b1;
      bcd_d  = sr_q[SR_W-1 -: DIGITS*4];
      ovf_d  = ovf_acc_q;
    end else begin
      done_d = 1'b0;
    end
  end

  // converter state and result registers
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= {DIGITS{BCD_BLANK}};
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/seg_bcd_scan.sv
// Binary-to-7-segment display: BCD conversion, optional leading-zero blanking
// (build macro SEG_LZB_EN) and common-anode digit scanning. Digit 0 is the most significant.
module seg_bcd_scan
  import seg_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input  logic                       s_clk,
  input  logic                       s_rst_n,
  input  logic                       load,
  input  logic [DATA_W-1:0]          bin_in,
  input  logic                       dp_en,
  input  logic [$clog2(DIGITS)-1:0]  dp_pos,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf,
  output logic [DIGITS-1:0]          seg_cs_n,
  output logic [7:0]                 seg_data
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int TCK_W = $clog2(SCAN_DIV);

  logic [DIGITS*4-1:0] bcd_s;
  logic                ovf_s;
  logic [3:0]          dig_s [DIGITS];
  logic [7:0]          pat_s;
  logic [TCK_W-1:0]    tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   cs_q;
  logic [7:0]          seg_q;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .s_clk   (s_clk),
    .s_rst_n (s_rst_n),
    .load    (load),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd_s),
    .ovf     (ovf_s)
  );

`ifdef SEG_LZB_EN
  logic lead_s;

  // blank leading zeros, never the last digit nor the digit carrying the dp
  always_comb begin
    lead_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (lead_s && (i < DIGITS-1) && (bcd_s[(DIGITS-1-i)*4 +: 4] == 4'd0) &&
          !(dp_en && (dp_pos == IDX_W'(i)))) begin
        dig_s[i] = BCD_BLANK;
      end else begin
        lead_s   = 1'b0;
        dig_s[i] = bcd_s[(DIGITS-1-i)*4 +: 4];
      end
    end
  end
`else
  // every digit shown as converted
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      dig_s[i] = bcd_s[(DIGITS-1-i)*4 +: 4];
    end
  end
`endif

  // segment pattern of the digit selected this cycle
  always_comb begin
    if (ovf_s) begin
      pat_s = SEG_DASH;
    end else if (dp_en && (dp_pos == idx_q)) begin
      pat_s = seg_of(dig_s[idx_q]) & 8'hFE;
    end else begin
      pat_s = seg_of(dig_s[idx_q]);
    end
  end

  // free-running scan tick and digit index
  always_comb begin
    if (tick_q == TCK_W'(SCAN_DIV-1)) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS-1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      tick_d = tick_q + TCK_W'(1);
      idx_d  = idx_q;
    end
  end

  // scan state and pin registers, select and pattern taken from the same index
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tick_q <= '0;
      idx_q  <= '0;
      cs_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
      cs_q   <= ~(DIGITS'(1) << idx_q);
      seg_q  <= pat_s;
    end
  end

  assign ovf      = ovf_s;
  assign seg_cs_n = cs_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Directed bench for seg_bcd_scan: a 4-digit and a 3-digit instance share stimulus.
module tb_seg_bcd_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [11:0] bin_in = 12'd0;
  logic        dp_en = 1'b0;
  logic [1:0]  dp_pos = 2'd0;

  logic       busy, done, ovf;
  logic [3:0] cs;
  logic [7:0] seg;
  logic       busy3, done3, ovf3;
  logic [2:0] cs3;
  logic [7:0] seg3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_bcd_scan #(.DATA_W(12), .DIGITS(4), .SCAN_DIV(4)) u_dut (
    .s_clk(clk), .s_rst_n(rst_n), .load(load), .bin_in(bin_in),
    .dp_en(dp_en), .dp_pos(dp_pos), .busy(busy), .done(done), .ovf(ovf),
    .seg_cs_n(cs), .seg_data(seg));

  seg_bcd_scan #(.DATA_W(12), .DIGITS(3), .SCAN_DIV(4)) u_dut3 (
    .s_clk(clk), .s_rst_n(rst_n), .load(load), .bin_in(bin_in),
    .dp_en(dp_en), .dp_pos(dp_pos), .busy(busy3), .done(done3), .ovf(ovf3),
    .seg_cs_n(cs3), .seg_data(seg3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    @(negedge clk);
    load   = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (done) begin
        n = c;
        break;
      end
    end
    chk({tag, "_latency"}, n, 32'd13);
    chk({tag, "_done3"}, {31'd0, done3}, 32'd1);
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_digit(input string tag, input int i, input logic [7:0] exp);
    logic [3:0] want;
    bit         hit;
    want = ~(4'd1 << i);
    hit  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (cs === want) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_sel"}, {31'd0, hit}, 32'd1);
    chk(tag, {24'd0, seg}, {24'd0, exp});
  endtask

  task automatic check_digit3(input string tag, input int i, input logic [7:0] exp);
    logic [2:0] want;
    bit         hit;
    want = ~(3'd1 << i);
    hit  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (cs3 === want) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_sel"}, {31'd0, hit}, 32'd1);
    chk(tag, {24'd0, seg3}, {24'd0, exp});
  endtask

  initial begin
    bit          seen;
    int          done_cnt;
    logic [3:0]  seq [4];
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_cs", {28'd0, cs}, 32'hF);
    chk("rst_seg", {24'd0, seg}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    check_digit("blank_d0", 0, 8'hFF);
    check_digit("blank_d2", 2, 8'hFF);

    // scan order, one digit every SCAN_DIV cycles
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (cs !== 4'b1110) begin
        seen = 1'b1;
        break;
      end
    end
    for (int c = 0; c < 40 && seen; c++) begin
      @(posedge clk);
      #1;
      if (cs === 4'b1110) break;
    end
    chk("scan_start", {28'd0, cs}, 32'hE);
    repeat (3) @(posedge clk);
    #1;
    chk("scan_hold", {28'd0, cs}, 32'hE);
    @(posedge clk);
    #1;
    chk("scan_1", {28'd0, cs}, {28'd0, seq[0]});
    for (int s = 1; s < 4; s++) begin
      repeat (4) @(posedge clk);
      #1;
      chk("scan_n", {28'd0, cs}, {28'd0, seq[s]});
    end

    // 3300
    do_load(12'd3300);
    wait_done("c3300");
    chk("c3300_ovf", {31'd0, ovf}, 32'd0);
    check_digit("c3300_d0", 0, 8'h0D);
    check_digit("c3300_d1", 1, 8'h0D);
    check_digit("c3300_d2", 2, 8'h03);
    check_digit("c3300_d3", 3, 8'h03);

    // small values, leading zeros
    do_load(12'd7);
    wait_done("c7");
`ifdef SEG_LZB_EN
    check_digit("c7_d0", 0, 8'hFF);
    check_digit("c7_d1", 1, 8'hFF);
    check_digit("c7_d2", 2, 8'hFF);
`else
    check_digit("c7_d0", 0, 8'h03);
    check_digit("c7_d1", 1, 8'h03);
    check_digit("c7_d2", 2, 8'h03);
`endif
    check_digit("c7_d3", 3, 8'h1F);
    do_load(12'd0);
    wait_done("c0");
`ifdef SEG_LZB_EN
    check_digit("c0_d1", 1, 8'hFF);
`else
    check_digit("c0_d1", 1, 8'h03);
`endif
    check_digit("c0_d3", 3, 8'h03);

    // over-range on the 3-digit instance
    do_load(12'd1000);
    wait_done("c1000");
    chk("c1000_ovf3", {31'd0, ovf3}, 32'd1);
    chk("c1000_ovf", {31'd0, ovf}, 32'd0);
    check_digit3("c1000_u3d0", 0, 8'hFD);
    check_digit3("c1000_u3d1", 1, 8'hFD);
    check_digit3("c1000_u3d2", 2, 8'hFD);
    check_digit("c1000_d0", 0, 8'h9F);
    check_digit("c1000_d3", 3, 8'h03);
    do_load(12'd999);
    wait_done("c999");
    chk("c999_ovf3", {31'd0, ovf3}, 32'd0);
    check_digit3("c999_u3d0", 0, 8'h09);
    check_digit3("c999_u3d1", 1, 8'h09);
    check_digit3("c999_u3d2", 2, 8'h09);

    // restart while busy: no done for the aborted value
    do_load(12'd100);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    do_load(12'd4095);
    chk("abort_no_done", done_cnt, 32'd0);
    wait_done("c4095");
    check_digit("c4095_d0", 0, 8'h99);
    check_digit("c4095_d1", 1, 8'h03);
    check_digit("c4095_d2", 2, 8'h09);
    check_digit("c4095_d3", 3, 8'h49);

    // decimal point
    dp_en  = 1'b1;
    dp_pos = 2'd1;
    do_load(12'd1234);
    wait_done("c1234");
    check_digit("dp_d0", 0, 8'h9F);
    check_digit("dp_d1", 1, 8'h24);
    check_digit("dp_d2", 2, 8'h0D);
    check_digit("dp_d3", 3, 8'h99);
    dp_en = 1'b0;

    // asynchronous reset mid-conversion
    do_load(12'd1000);
    wait_done("pre_rst");
    do_load(12'd2000);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_ovf3", {31'd0, ovf3}, 32'd0);
    chk("arst_busy3", {31'd0, busy3}, 32'd0);
    chk("arst_cs", {28'd0, cs}, 32'hF);
    chk("arst_seg", {24'd0, seg}, 32'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done || done3) done_cnt++;
    end
    chk("post_rst_no_done", done_cnt, 32'd0);
    check_digit("post_rst_d1", 1, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_bcd_scan.md
Name: seg_bcd_scan

Overview:
Parametrised successor to the fixed 4-digit ADC voltage display.
- Accepts a DATA_W-bit binary value on a load strobe and converts it to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Latches the result into display registers and time-multiplexes them onto a common-anode 7-segment bank.
- Adds over-range indication, a programmable decimal point and a handshake that the earlier design lacked.
- Sits between the ADC capture logic and the board segment pins.

Parameters:
DATA_W, 12, width of binary input value (>=4)
DIGITS, 4, number of display digits / BCD digits (2..8)
SCAN_DIV, 100000, s_clk cycles each digit is enabled (>=2)

Ports:
s_clk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; samples bin_in
bin_in  in  DATA_W  binary value to display
dp_en  in  1  enable decimal point
dp_pos  in  $clog2(DIGITS)  digit index carrying the dp (0 = most significant)
busy  out  1  conversion in progress
done  out  1  one-cycle pulse; display registers updated
ovf  out  1  last converted value >= 10^DIGITS
seg_cs_n  out  DIGITS  active-low digit select, one-hot low; bit i drives digit i
seg_data  out  8  active-low segments {a,b,c,d,e,f,g,dp}, bit7=a

Behaviour:
Reset, asynchronous, active-low, on s_rst_n with clock s_clk. Reset values:
- busy=0, done=0, ovf=0
- seg_cs_n=all 1, seg_data=8'hFF
- all display digits = blank code 4'hA
- scan counter and digit index = 0

Conversion:
- load sampled at edge k.
- busy=1 from k+1; one shift per cycle, DATA_W shifts.
- done=1 for exactly one cycle DATA_W+1 cycles after k, i.e. 13 cycles for DATA_W=12.
- The display registers and ovf update on the same edge that raises done; busy falls on that edge.
- load while busy restarts the conversion with the new bin_in. No done is issued for the aborted value, and the display keeps the previous result.
- load coincident with done: done still pulses for the finished value, and the new conversion starts.

Arithmetic:
- Shift register width DIGITS*4 + DATA_W.
- Before each shift, add 3 to each BCD nibble >= 5.
- ovf is set if a 1 is shifted out of the top BCD nibble at any step.
- When ovf=1, every digit displays dash (g only: 8'b11111101) and dp is suppressed.

Scan:
- Tick counter runs 0..SCAN_DIV-1 free-running, independent of conversion.
- At wrap, digit index increments modulo DIGITS.
- seg_cs_n and seg_data are both registered from the same index, giving one cycle of latency and keeping them aligned.
- Active digit i drives seg_cs_n[i]=0, all others 1.

Segment codes, active-low, dp bit=1 (off):
- 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99
- 5=0x49, 6=0x41, 7=0x1F, 8=0x01, 9=0x09
- blank(A)=0xFF, dash=0xFD
- dp: bit0 is cleared when dp_en=1 and index==dp_pos (not in ovf).

Optional Feature:
Macro SEG_LZB_EN (leading-zero blanking):
- Defined: leading zero digits are replaced by the blank code at the done edge.
- Blanking stops at the first non-zero digit, at the least significant digit (value 0 shows a single "0"), and at dp_pos when dp_en=1.
- Undefined: all digits are shown, including leading zeros.

Decomposition:
- Package seg_pkg: 8-bit segment pattern constants for 0-9, SEG_BLANK, SEG_DASH, BCD_BLANK=4'hA, and a digit-to-segment function.
- Sub-module bin2bcd_seq (params DATA_W, DIGITS; ports s_clk, s_rst_n, load, bin_in, busy, done, bcd, ovf) holds the sequential converter.
- Top module holds the display registers, blanking, scan counter and output registers.

Test Plan:
1. Default params, load bin_in=3300 → done exactly 13 cycles later, ovf=0. Then:
   - seg_cs_n=4'b1110 → seg_data 0x0D
   - seg_cs_n=4'b1101 → seg_data 0x0D
   - seg_cs_n=4'b1011 → seg_data 0x03
   - seg_cs_n=4'b0111 → seg_data 0x03
2. SCAN_DIV=4 → seg_cs_n sequence 1110, 1101, 1011, 0111, 1110 changing every 4 cycles; load=7 with SEG_LZB_EN → digits 0-2 = 0xFF, digit 3 = 0x1F; without macro → 0x03, 0x03, 0x03, 0x1F.
3. DIGITS=3, load 1000 → ovf=1, all digits 0xFD; then load 999 → ovf=0, digits 0x09 ×3.
4. load 100, then load 4095 four cycles later → single done 13 cycles after second load, display 4, 0, 9, 5, no done for 100.
5. dp_en=1, dp_pos=1, load 1234 → digit 1 seg_data 0x24 (2 with dp), other digits dp off.
6. Assert s_rst_n=0 mid-conversion (cycle 6) → busy, done, ovf 0, seg_cs_n all 1, seg_data 0xFF immediately; no done after release.
